// File: rtl/aes_pkg.sv
// Shared AES front-end definitions: block geometry, PKCS#7 constants,
// packer FSM state and the packer's debug view.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_BITS  = 128;

  // Pad byte used for the extra block when a message ends on a block boundary.
  localparam logic [7:0] PKCS7_FULL_PAD = 8'h10;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Internal state exported for observation by checkers.
  typedef struct packed {
    state_e     state;
    logic [3:0] idx;
    logic       pad_pending;
  } packer_dbg_t;

  // Return blk with byte slot 'slot' replaced by b. Slot 0 is bits [127:120].
  function automatic logic [AES_BLOCK_BITS-1:0] set_slot(
    input logic [AES_BLOCK_BITS-1:0] blk,
    input logic [3:0]                slot,
    input logic [7:0]                b
  );
    logic [AES_BLOCK_BITS-1:0] r;
    r = blk;
    for (int s = 0; s < AES_BLOCK_BYTES; s++) begin
      if (4'(s) == slot) begin
        r[AES_BLOCK_BITS-1-8*s -: 8] = b;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pkcs7_fill.sv
// Pads every slot after the last real byte of a block, either with the
// PKCS#7 count byte or with zeros.
module pkcs7_fill
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_BITS-1:0] blk_i,
  input  logic [3:0]                last_idx_i,
  input  logic                      pad_en_i,
  output logic [AES_BLOCK_BITS-1:0] blk_o
);

  logic [7:0] pad_val;

  // Per-slot mux: keep real bytes up to last_idx_i, pad the remainder.
  always_comb begin
    pad_val = pad_en_i ? {4'h0, 4'hF - last_idx_i} : 8'h00;
    blk_o   = blk_i;
    for (int s = 0; s < AES_BLOCK_BYTES; s++) begin
      if (4'(s) > last_idx_i) begin
        blk_o[AES_BLOCK_BITS-1-8*s -: 8] = pad_val;
      end
    end
  end

endmodule

// File: rtl/plaintext_packer.sv
// Byte-serial message stream in, 16-byte plaintext blocks out, with PKCS#7
// padding (or zero fill) on the final block of each message.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. The producer holds data stable while valid is high and ready is
// low; ready never depends on valid. in_ready is high only while filling and
// block_valid only while holding, so a byte is never accepted in a cycle
// where block_ready is sampled.
module plaintext_packer
  import aes_pkg::*;
#(
  parameter bit PAD_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                in_byte,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [AES_BLOCK_BITS-1:0] plaintext,
  output logic                      block_valid,
  output logic                      block_last,
  input  logic                      block_ready,
  output packer_dbg_t               dbg
);

  state_e                    state_q, state_d;
  logic [3:0]                idx_q, idx_d;
  logic [AES_BLOCK_BITS-1:0] pt_q, pt_d;
  logic                      last_q, last_d;
  logic                      pend_q, pend_d;

  logic [AES_BLOCK_BITS-1:0] merged_blk;
  logic [AES_BLOCK_BITS-1:0] filled_blk;

  assign merged_blk = set_slot(pt_q, idx_q, in_byte);

  // Slots after idx_q are padded when the current byte closes the message.
  pkcs7_fill u_fill (
    .blk_i      (merged_blk),
    .last_idx_i (idx_q),
    .pad_en_i   (PAD_EN),
    .blk_o      (filled_blk)
  );

  assign in_ready    = (state_q == FILL);
  assign block_valid = (state_q == HOLD);
  assign plaintext   = pt_q;
  assign block_last  = last_q;
  assign dbg         = '{state: state_q, idx: idx_q, pad_pending: pend_q};

  // Next-state: collect bytes in FILL, present and retire blocks in HOLD.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pt_d    = pt_q;
    last_d  = last_q;
    pend_d  = pend_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          pt_d = in_last ? filled_blk : merged_blk;
          if (in_last) begin
            state_d = HOLD;
            // A message ending exactly on slot 15 needs a whole pad block.
            if (PAD_EN && (idx_q == 4'd15)) begin
              last_d = 1'b0;
              pend_d = 1'b1;
            end else begin
              last_d = 1'b1;
            end
          end else if (idx_q == 4'd15) begin
            state_d = HOLD;
            last_d  = 1'b0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      HOLD: begin
        if (block_ready) begin
          if (pend_q) begin
            pt_d   = {AES_BLOCK_BYTES{PKCS7_FULL_PAD}};
            last_d = 1'b1;
            pend_d = 1'b0;
          end else begin
            state_d = FILL;
            idx_d   = 4'd0;
            last_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = 4'd0;
      end
    endcase
  end

  // State register with synchronous reset; reset drops any partial block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= 4'd0;
      pt_q    <= '0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pt_q    <= pt_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_plaintext_packer.sv
// Bench for plaintext_packer: instance 0 with PKCS#7 padding, instance 1 with
// zero fill. Expected blocks are derived from whole messages and checked by a
// per-instance monitor at each block handshake.
module tb_plaintext_packer;
  import aes_pkg::*;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_byte     [N];
  logic         in_valid    [N];
  logic         in_last     [N];
  logic         in_ready    [N];
  logic [127:0] plaintext   [N];
  logic         block_valid [N];
  logic         block_last  [N];
  logic         block_ready [N];
  packer_dbg_t  dbg         [N];

  logic [128:0] exp_q [N][$];   // {block_last, plaintext}
  int total = 0;
  int bad   = 0;
  int stall_cycles [N];
  int max_gap = 0;

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst,
                     input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h", name, inst, act, exp);
    end
  endtask

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      logic         held;
      logic [127:0] held_pt;
      logic         held_last;
      logic [128:0] e;

      plaintext_packer #(.PAD_EN(g == 0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte[g]),
        .in_valid    (in_valid[g]),
        .in_last     (in_last[g]),
        .in_ready    (in_ready[g]),
        .plaintext   (plaintext[g]),
        .block_valid (block_valid[g]),
        .block_last  (block_last[g]),
        .block_ready (block_ready[g]),
        .dbg         (dbg[g])
      );

      // Encryptor model: random acceptance, with an optional forced stall.
      initial begin
        block_ready[g] = 1'b0;
        forever begin
          @(posedge clk);
          #2;
          if (stall_cycles[g] > 0 && block_valid[g]) begin
            block_ready[g] = 1'b0;
            stall_cycles[g]--;
          end else begin
            block_ready[g] = ($urandom_range(0, 3) != 0);
          end
        end
      end

      // Monitor: block handshakes, hold stability, in_ready exclusivity.
      initial held = 1'b0;
      always @(negedge clk) begin
        if (rst) begin
          held = 1'b0;
        end else begin
          if (held) begin
            chk("hold_plaintext", g, plaintext[g], held_pt);
            chk("hold_valid", g, 128'(block_valid[g]), 128'(1));
            chk("hold_last", g, 128'(block_last[g]), 128'(held_last));
          end
          chk("in_ready_vs_valid", g, 128'(in_ready[g]), 128'(!block_valid[g]));
          if (block_valid[g] && block_ready[g]) begin
            if (exp_q[g].size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_block inst=%0d got=%h want=none", g, plaintext[g]);
            end else begin
              e = exp_q[g].pop_front();
              chk("block_data", g, plaintext[g], e[127:0]);
              chk("block_last", g, 128'(block_last[g]), 128'(e[128]));
            end
          end
          held      = block_valid[g] && !block_ready[g];
          held_pt   = plaintext[g];
          held_last = block_last[g];
        end
      end
    end
  endgenerate

  // Reference: pad the whole message, cut into 16-byte blocks, flag the last.
  function automatic void push_model(input int i, input logic [7:0] msg[$]);
    logic [7:0]   bytes[$];
    logic [127:0] blk;
    int           n, p, nblk;
    bytes = msg;
    n = msg.size();
    if (i == 0) begin
      p = 16 - (n % 16);
      for (int k = 0; k < p; k++) bytes.push_back(8'(p));
    end else begin
      while (bytes.size() % 16 != 0) bytes.push_back(8'h00);
    end
    nblk = bytes.size() / 16;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int s = 0; s < 16; s++) blk = {blk[119:0], bytes[16*b+s]};
      exp_q[i].push_back({(b == nblk - 1), blk});
    end
  endfunction

  // Offer one byte and keep it offered until accepted (bounded).
  task automatic drive_byte(input int i, input logic [7:0] b, input logic last);
    bit acc;
    bit ok;
    ok = 1'b0;
    in_byte[i]  = b;
    in_last[i]  = last;
    in_valid[i] = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      acc = in_ready[i];
      @(posedge clk);
      #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid[i] = 1'b0;
    in_last[i]  = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL byte_accept_timeout inst=%0d got=not_accepted want=accepted", i);
    end
    repeat ($urandom_range(0, max_gap)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_msg(input int i, input logic [7:0] msg[$]);
    push_model(i, msg);
    for (int k = 0; k < msg.size(); k++) drive_byte(i, msg[k], k == msg.size() - 1);
  endtask

  task automatic wait_drain(input int i);
    bit done;
    done = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (exp_q[i].size() == 0 && !block_valid[i]) begin
        done = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout inst=%0d got=%0d want=0", i, exp_q[i].size());
    end
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_plaintext", i, plaintext[i], 128'(0));
      chk("rst_block_valid", i, 128'(block_valid[i]), 128'(0));
      chk("rst_block_last", i, 128'(block_last[i]), 128'(0));
      chk("rst_in_ready", i, 128'(in_ready[i]), 128'(1));
      chk("rst_idx", i, 128'(dbg[i].idx), 128'(0));
    end
    @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    logic [7:0] m[$];
    for (int i = 0; i < N; i++) begin
      in_byte[i] = 8'h00; in_valid[i] = 1'b0; in_last[i] = 1'b0;
      stall_cycles[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    // 16 bytes 0x00..0x0F, padded: data block then full pad block.
    m = {};
    for (int k = 0; k < 16; k++) m.push_back(8'(k));
    send_msg(0, m);
    wait_drain(0);

    // Short message in both modes.
    m = {8'hAA, 8'hBB, 8'hCC};
    send_msg(0, m);
    send_msg(1, m);
    wait_drain(0);
    wait_drain(1);

    // 16-byte message with zero fill: exactly one block.
    m = {};
    for (int k = 0; k < 16; k++) m.push_back(8'(8'hF0 + k));
    send_msg(1, m);
    wait_drain(1);

    // Encryptor stalls 20 cycles on the first block while bytes keep coming.
    stall_cycles[0] = 20;
    m = {};
    for (int k = 0; k < 20; k++) m.push_back(8'(8'h40 + k));
    send_msg(0, m);
    wait_drain(0);

    // 33-byte message: three blocks, last only on the third.
    m = {};
    for (int k = 0; k < 33; k++) m.push_back(8'(k));
    send_msg(0, m);
    wait_drain(0);

    // Reset in the middle of a block discards the partial data.
    for (int k = 0; k < 7; k++) drive_byte(0, 8'(8'h70 + k), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();
    m = {8'h55};
    send_msg(0, m);
    wait_drain(0);

    // Random messages with random gaps on both instances.
    max_gap = 2;
    for (int r = 0; r < 24; r++) begin
      int len;
      int inst;
      len  = $urandom_range(1, 40);
      inst = r % 2;
      m = {};
      for (int k = 0; k < len; k++) m.push_back(8'($urandom_range(0, 255)));
      send_msg(inst, m);
    end
    wait_drain(0);
    wait_drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plaintext_packer.md
Name: plaintext_packer

Overview:
- Upstream stage of the AES encryptor: accepts a byte-serial message stream and assembles 16-byte plaintext blocks.
- Applies PKCS#7 padding to the final block of each message.
- Presents each 128-bit block to the encryptor with a valid/ready handshake and holds it stable until the encryptor accepts it.
- Byte 0 of each block is the first byte received and maps to plaintext[127:120], matching the encryptor's column-major state layout.

Parameters:
- PAD_EN, 1, 1 = PKCS#7 padding (extra full pad block when the message length is a multiple of 16); 0 = zero-fill partial final block, no extra block.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_byte  in  8  message byte.
- in_valid  in  1  in_byte is valid.
- in_last  in  1  qualifies in_byte as the final byte of the message.
- in_ready  out  1  packer accepts a byte this cycle (transfer = in_valid & in_ready).
- plaintext  out  128  assembled block to the encryptor.
- block_valid  out  1  plaintext holds a complete block.
- block_last  out  1  this block is the final block of its message.
- block_ready  in  1  encryptor accepts the block (transfer = block_valid & block_ready).

Behaviour:
- Reset: synchronous, active-high; clock is clk. On rst: state=FILL, byte index=0, plaintext=0, block_valid=0, block_last=0, pad_pending=0, in_ready=1 from the next cycle. rst mid-block or mid-hold discards all partial data; there is no flush.
- States: FILL, HOLD.
- FILL:
  - in_ready=1, block_valid=0.
  - On byte transfer, write in_byte into slot idx (bits [127-8*idx -: 8]) and increment idx.
  - idx<15, in_last=0: stay in FILL.
  - idx==15, in_last=0: go to HOLD, block_last=0.
  - idx<15, in_last=1: in the same cycle fill slots idx+1..15 with pad value P=15-idx (PAD_EN=1) or 0x00 (PAD_EN=0). Go to HOLD, block_last=1.
  - idx==15, in_last=1: go to HOLD. If PAD_EN=1: block_last=0 and pad_pending=1. If PAD_EN=0: block_last=1.
- HOLD:
  - in_ready=0, block_valid=1; plaintext and block_last are stable.
  - On block_ready with pad_pending=1: load plaintext with 16 bytes of 0x10, block_last=1, pad_pending=0, stay in HOLD.
  - On block_ready with pad_pending=0: go to FILL, idx=0, block_valid=0.
- Latency: block_valid rises the cycle after the 16th byte (or the last byte) is accepted.
- No byte is accepted in the cycle block_ready is sampled. Minimum period is 17 cycles per full block.
- in_valid while in_ready=0 is ignored; the source holds the byte. block_ready while block_valid=0 is ignored.
- in_byte and in_last are sampled only on a transfer.
- A message of length 0 cannot be expressed; in_last always qualifies a real byte.
- idx is 4 bits, wraps 15→0 only via the HOLD→FILL transition; it never wraps in FILL.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_BYTES=16, AES_BLOCK_BITS=128.
  - PKCS7_FULL_PAD=8'h10.
  - State enum {FILL, HOLD}.
- One combinational sub-module, pkcs7_fill: inputs partial block, last index, PAD_EN; output padded block. Keeps the per-slot mux out of the FSM.

Test Plan:
- 16 bytes 0x00..0x0F, in_last on 0x0F, PAD_EN=1, block_ready=1 → block 0x000102…0F with block_last=0, then block 0x1010…10 with block_last=1, then in_ready=1.
- 3 bytes 0xAA,0xBB,0xCC with in_last on 0xCC → single block 0xAABBCC0D0D…0D (13×0x0D), block_last=1.
- Same 3 bytes, PAD_EN=0 → 0xAABBCC000…00, block_last=1. 16-byte message gives one block only, block_last=1.
- block_ready held 0 for 20 cycles after block_valid, in_valid=1 throughout → plaintext stable, in_ready=0, no byte lost. Next byte is accepted only after the handshake.
- 33-byte message (bytes = index) → three blocks. Third is 0x20 followed by 15×0x0F; block_last only on the third.
- rst asserted after 7 bytes, then a 1-byte message 0x55 → block 0x55 followed by 15×0x0F; earlier bytes absent, all outputs 0 in the cycle after rst.
